wrdata_strobe_gen: RTL and testbench
====================================

Name: wrdata_strobe_gen

Overview:
- Write-data serializer. Sits directly downstream of the command/address stage and consumes its burst_length, pre_pattern, pre_cycle, post_cycle and DRAM_CRC_en outputs.
- On a write start it drives the DQS preamble, then the toggling data strobe with DQ data beats, then optional CRC beats, then the DQS postamble toward the DRAM interface.
- Runs at UI rate: one clock equals one DQS half-period.

Parameters:
DQ_WIDTH, 8, data bits per beat (CRC logic supports 8 only).

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous active-low reset
i_enable  in  1  clock enable; low freezes all state and outputs
i_wr_start  in  1  single-cycle write start pulse
i_burst_length  in  6  burst length from CA stage (8/16/32)
i_pre_pattern  in  8  preamble bit pattern
i_pre_cycle  in  3  preamble length in tCK (2..4)
i_post_cycle  in  2  01 = 0.5 tCK, 10 = 1.5 tCK
i_crc_en  in  1  append CRC beats
i_wrdata  in  DQ_WIDTH  write data beat, valid in cycles where o_data_req=1
o_data_req  out  1  consume i_wrdata this cycle
o_dqs  out  1  DQS_t level
o_dqs_oe  out  1  DQS drive enable
o_dq  out  DQ_WIDTH  DQ beat
o_dq_oe  out  1  DQ drive enable
o_busy  out  1  burst in progress
o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: i_reset asynchronous, active-low; clock i_clock. All outputs reset to 0, state reset to IDLE, counters and CRC reset to 0. Reset mid-burst aborts immediately, with no postamble.
- FSM states: IDLE, PRE, DATA, CRC, POST.
- All DQ/DQS outputs are registered. o_data_req is combinational from state.
- Start:
  - i_wr_start is accepted only in IDLE with i_enable=1. It is ignored in all other states, including the POST state.
  - All config inputs are latched at the start edge.
  - Illegal config is sanitized at latch: i_pre_cycle outside 2..4 is treated as 2; i_burst_length not in {8,16,32} is treated as 16; i_post_cycle other than 10 is treated as 01.
- Timing, with the start sampled at edge 0 and P = 2×pre_cycle UIs:
  - Output cycles 1..P: o_dqs = pre_pattern[P-1] down to pre_pattern[0]; o_dqs_oe=1; o_dq_oe=0; o_dq=0.
  - Cycles P+1..P+BL: o_dqs alternates 1,0,1,0…; o_dq = beat; o_dq_oe=1.
  - o_data_req is high in cycles P..P+BL-1. i_wrdata sampled in cycle n appears on o_dq in cycle n+1.
  - If crc_en: 2 further UIs with DQS continuing to toggle. Beat 0 is the CRC byte; beat 1 is 8'hFF.
  - POST: o_dqs=0, o_dqs_oe=1, o_dq_oe=0, for 1 UI (post 01) or 3 UIs (post 10).
  - Next cycle: o_dqs_oe=0, o_dqs=0, o_done=1 for one cycle, o_busy=0.
- o_busy is high from cycle 1 through the last POST cycle.
- CRC definition:
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first.
  - Accumulated over every i_wrdata byte captured while o_data_req=1.
  - Cleared at start.
- Counter: 6-bit beat counter, reloaded on each state entry; a state exits when the counter reaches 0.
- i_enable=0 mid-burst: every register holds and o_data_req is forced to 0. The burst resumes exactly where it stopped.

Decomposition:
- Package wrdata_pkg:
  - FSM state enum.
  - Burst-length, preamble and postamble code constants.
  - CRC8_POLY constant.
  - Pure function crc8_next(crc, byte).
- No sub-module. The FSM, counter and CRC accumulator sit in one module.

Test Plan:
- Default config (pre 2, BL16, post 01, CRC off), start at cycle 0 → o_dqs = 0,0,1,0 in cycles 1–4; toggling 1/0 with o_dq_oe=1 in cycles 5–20; o_dqs=0 with oe=1 in cycle 21; o_done=1 and oe=0 in cycle 22. o_data_req high in cycles 4–19.
- pre_cycle=4, pattern 8'b00001010, BL8, post 10 → preamble 0,0,0,0,1,0,1,0 in cycles 1–8; 8 data beats; 3 postamble UIs; done at cycle 20.
- BL8, CRC on, data 0x00×7 then 0x01 → CRC beats 0x07 then 0xFF, DQS toggling through both.
- i_wr_start pulsed during DATA and during POST → ignored; exactly one burst; o_done pulses once.
- i_enable low for 3 cycles mid-DATA → outputs hold, o_data_req=0; resumes with the remaining beats, total beat count unchanged.
- i_reset asserted mid-PRE → all outputs 0 immediately; a new start after reset release produces a clean full burst.

Source files
------------

// File: rtl/wrdata_pkg.sv
// Shared types, code points and the CRC-8 step function for the write-data serializer.
package wrdata_pkg;

  localparam int unsigned CNT_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_CRC,
    ST_POST
  } state_e;

  localparam logic [5:0] BL_8  = 6'd8;
  localparam logic [5:0] BL_16 = 6'd16;
  localparam logic [5:0] BL_32 = 6'd32;

  localparam logic [2:0] PRE_MIN = 3'd2;
  localparam logic [2:0] PRE_MAX = 3'd4;

  localparam logic [1:0] POST_HALF     = 2'b01;
  localparam logic [1:0] POST_ONE_HALF = 2'b10;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One byte of MSB-first CRC-8 update.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/wrdata_strobe_gen.sv
// Write-data serializer: DQS preamble, toggling strobe with DQ beats, optional CRC beats, postamble.
module wrdata_strobe_gen
  import wrdata_pkg::*;
#(
  parameter int unsigned DQ_WIDTH = 8
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_wr_start,
  input  logic [5:0]          i_burst_length,
  input  logic [7:0]          i_pre_pattern,
  input  logic [2:0]          i_pre_cycle,
  input  logic [1:0]          i_post_cycle,
  input  logic                i_crc_en,
  input  logic [DQ_WIDTH-1:0] i_wrdata,
  output logic                o_data_req,
  output logic                o_dqs,
  output logic                o_dqs_oe,
  output logic [DQ_WIDTH-1:0] o_dq,
  output logic                o_dq_oe,
  output logic                o_busy,
  output logic                o_done
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          crc_q, crc_d;
  logic [7:0]          pat_q, pat_d;
  logic [5:0]          bl_q, bl_d;
  logic                post_long_q, post_long_d;
  logic                crc_en_q, crc_en_d;
  logic                dqs_q, dqs_d;
  logic                dqs_oe_q, dqs_oe_d;
  logic [DQ_WIDTH-1:0] dq_q, dq_d;
  logic                dq_oe_q, dq_oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [2:0]          pre_s;
  logic [CNT_W-1:0]    pre_m1;
  logic [5:0]          bl_s;
  logic                enter_post;

  // Config sanitization applied at the start edge.
  always_comb begin
    pre_s  = (i_pre_cycle >= PRE_MIN && i_pre_cycle <= PRE_MAX) ? i_pre_cycle : PRE_MIN;
    pre_m1 = CNT_W'({pre_s, 1'b0}) - CNT_W'(1);
    bl_s   = (i_burst_length == BL_8 || i_burst_length == BL_16 || i_burst_length == BL_32)
             ? i_burst_length : BL_16;
  end

  // Data is requested on the last preamble UI and all but the last data UI.
  always_comb begin
    o_data_req = i_enable && (((state_q == ST_PRE) && (cnt_q == '0)) ||
                              ((state_q == ST_DATA) && (cnt_q != '0)));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    pat_d       = pat_q;
    bl_d        = bl_q;
    post_long_d = post_long_q;
    crc_en_d    = crc_en_q;
    dqs_d       = dqs_q;
    dqs_oe_d    = dqs_oe_q;
    dq_d        = dq_q;
    dq_oe_d     = dq_oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    enter_post  = 1'b0;

    if (o_data_req) crc_d = crc8_next(crc_q, 8'(i_wrdata));

    unique case (state_q)
      ST_IDLE: begin
        if (i_wr_start) begin
          state_d     = ST_PRE;
          cnt_d       = pre_m1;
          crc_d       = '0;
          pat_d       = i_pre_pattern;
          bl_d        = bl_s;
          post_long_d = (i_post_cycle == POST_ONE_HALF);
          crc_en_d    = i_crc_en;
          dqs_d       = i_pre_pattern[pre_m1[2:0]];
          dqs_oe_d    = 1'b1;
          dq_d        = '0;
          dq_oe_d     = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_PRE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          dqs_d = pat_q[3'(cnt_q - CNT_W'(1))];
        end else begin
          state_d = ST_DATA;
          cnt_d   = bl_q - 6'd1;
          dqs_d   = 1'b1;
          dq_d    = i_wrdata;
          dq_oe_d = 1'b1;
        end
      end
      ST_DATA: begin
        dqs_d = ~dqs_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          dq_d  = i_wrdata;
        end else if (crc_en_q) begin
          state_d = ST_CRC;
          cnt_d   = CNT_W'(1);
          dq_d    = DQ_WIDTH'(crc_q);
        end else begin
          enter_post = 1'b1;
        end
      end
      ST_CRC: begin
        dqs_d = ~dqs_q;
        if (cnt_q != '0) begin
          cnt_d = '0;
          dq_d  = '1;
        end else begin
          enter_post = 1'b1;
        end
      end
      ST_POST: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d  = ST_IDLE;
          dqs_d    = 1'b0;
          dqs_oe_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Postamble: strobe parked low but still driven.
    if (enter_post) begin
      state_d  = ST_POST;
      cnt_d    = post_long_q ? CNT_W'(2) : CNT_W'(0);
      dqs_d    = 1'b0;
      dqs_oe_d = 1'b1;
      dq_d     = '0;
      dq_oe_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      crc_q       <= '0;
      pat_q       <= '0;
      bl_q        <= '0;
      post_long_q <= 1'b0;
      crc_en_q    <= 1'b0;
      dqs_q       <= 1'b0;
      dqs_oe_q    <= 1'b0;
      dq_q        <= '0;
      dq_oe_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (i_enable) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      pat_q       <= pat_d;
      bl_q        <= bl_d;
      post_long_q <= post_long_d;
      crc_en_q    <= crc_en_d;
      dqs_q       <= dqs_d;
      dqs_oe_q    <= dqs_oe_d;
      dq_q        <= dq_d;
      dq_oe_q     <= dq_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_dqs    = dqs_q;
  assign o_dqs_oe = dqs_oe_q;
  assign o_dq     = dq_q;
  assign o_dq_oe  = dq_oe_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_wrdata_strobe_gen.sv
// Scoreboard bench: per-UI expected outputs built from burst rules, compared by an independent monitor.
module tb_wrdata_strobe_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       wr_start;
  logic [5:0] bl;
  logic [7:0] pat;
  logic [2:0] pre;
  logic [1:0] post;
  logic       crc_en;
  logic [7:0] wrdata;
  logic       data_req, dqs, dqs_oe, dq_oe, busy, done;
  logic [7:0] dq;

  always #5 clk = ~clk;

  wrdata_strobe_gen #(.DQ_WIDTH(8)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_wr_start(wr_start),
    .i_burst_length(bl), .i_pre_pattern(pat), .i_pre_cycle(pre), .i_post_cycle(post),
    .i_crc_en(crc_en), .i_wrdata(wrdata), .o_data_req(data_req), .o_dqs(dqs),
    .o_dqs_oe(dqs_oe), .o_dq(dq), .o_dq_oe(dq_oe), .o_busy(busy), .o_done(done)
  );

  typedef struct packed {
    logic       dqs;
    logic       dqs_oe;
    logic [7:0] dq;
    logic       dq_oe;
    logic       busy;
    logic       done;
    logic       req;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          done_exp = 0;
  logic        cur_req = 1'b0;
  logic [12:0] prev_out = '0;
  logic        last_en = 1'b1;

  logic [7:0]  data_arr [64];
  logic [5:0]  beat_idx = '0;
  logic        beat_clr = 1'b0;

  assign wrdata = data_arr[beat_idx];

  // Source side: hand out the next byte each time one is consumed.
  always @(posedge clk) begin
    if (beat_clr) beat_idx <= '0;
    else if (data_req) beat_idx <= beat_idx + 6'd1;
  end

  always @(posedge clk) last_en <= en;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: one expected record per advancing UI while the DUT presents a burst.
  always @(negedge clk) begin
    exp_t        r;
    logic [12:0] cur;
    cur = {dqs, dqs_oe, dq, dq_oe, busy, done};
    if (rst_n) begin
      if (last_en && (busy || done)) begin
        if (done) done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(cur), 32'(0));
        end else begin
          r = exp_q.pop_front();
          check("burst_ui", 32'(cur), 32'({r.dqs, r.dqs_oe, r.dq, r.dq_oe, r.busy, r.done}));
          cur_req = r.req;
        end
      end else if (last_en) begin
        cur_req = 1'b0;
        check("idle_out", 32'(cur), 32'(0));
      end else begin
        check("stall_hold", 32'(cur), 32'(prev_out));
      end
      check("data_req", 32'(data_req), 32'(cur_req && en));
      prev_out = cur;
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 64; i++) data_arr[i] = 8'($urandom);
  endtask

  // Expected per-UI output sequence for one burst, straight from the burst rules.
  task automatic push_model(input logic [2:0] pre_in, input logic [7:0] pat_in,
                            input logic [5:0] bl_in, input logic [1:0] post_in,
                            input logic crc_in, output int total, output int p);
    int         nbl, npost;
    exp_t       r;
    logic [7:0] c;
    logic       fb;
    p     = (pre_in >= 3'd2 && pre_in <= 3'd4) ? 2 * int'(pre_in) : 4;
    nbl   = (bl_in == 6'd8 || bl_in == 6'd16 || bl_in == 6'd32) ? int'(bl_in) : 16;
    npost = (post_in == 2'b10) ? 3 : 1;
    total = 0;
    for (int k = 1; k <= p; k++) begin
      r = '0; r.dqs = pat_in[3'(p - k)]; r.dqs_oe = 1'b1; r.busy = 1'b1; r.req = (k == p);
      exp_q.push_back(r); total++;
    end
    for (int j = 1; j <= nbl; j++) begin
      r = '0; r.dqs = (j % 2 == 1); r.dqs_oe = 1'b1; r.dq = data_arr[j - 1];
      r.dq_oe = 1'b1; r.busy = 1'b1; r.req = (j < nbl);
      exp_q.push_back(r); total++;
    end
    if (crc_in) begin
      c = 8'h00;
      for (int j = 0; j < nbl; j++)
        for (int b = 7; b >= 0; b--) begin
          fb = c[7] ^ data_arr[j][b];
          c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
      for (int j = 0; j < 2; j++) begin
        r = '0; r.dqs = (j == 0); r.dqs_oe = 1'b1; r.dq = (j == 0) ? c : 8'hFF;
        r.dq_oe = 1'b1; r.busy = 1'b1;
        exp_q.push_back(r); total++;
      end
    end
    for (int j = 0; j < npost; j++) begin
      r = '0; r.dqs_oe = 1'b1; r.busy = 1'b1;
      exp_q.push_back(r); total++;
    end
    r = '0; r.done = 1'b1;
    exp_q.push_back(r); total++;
  endtask

  // noise_mode: 0 none, 1 random starts, 2 starts at UI noise_a and on the last postamble UI.
  task automatic run_burst(input logic [2:0] pre_in, input logic [7:0] pat_in, input logic [5:0] bl_in,
                           input logic [1:0] post_in, input logic crc_in, input int stall_pct,
                           input int noise_mode, input int noise_a, input int stall_at, input int abort_at);
    int   total, p, n, stall_left;
    logic en_prev, reached, stall_done, e;
    @(posedge clk); #1;
    wr_start = 1'b1; en = 1'b1; beat_clr = 1'b1;
    pre = pre_in; pat = pat_in; bl = bl_in; post = post_in; crc_en = crc_in;
    push_model(pre_in, pat_in, bl_in, post_in, crc_in, total, p);
    en_prev = 1'b1; n = 0; reached = 1'b0; stall_left = 0; stall_done = 1'b0;
    for (int it = 0; it < 600; it++) begin
      @(posedge clk); #1;
      if (en_prev) n++;
      wr_start = 1'b0; beat_clr = 1'b0;
      pre = 3'($urandom); pat = 8'($urandom); bl = 6'($urandom);
      post = 2'($urandom); crc_en = 1'($urandom);
      if (abort_at > 0 && n == abort_at) begin
        #1 rst_n = 1'b0;
        #1 check("abort_zero", 32'({dqs, dqs_oe, dq, dq_oe, busy, done, data_req}), 32'(0));
        exp_q.delete();
        cur_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1;
        return;
      end
      if (n >= total) begin
        en = 1'b1; reached = 1'b1;
        break;
      end
      e = 1'b1;
      if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) e = 1'b0;
      if (stall_at > 0 && n == stall_at && !stall_done) begin
        stall_left = 3; stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        e = 1'b0; stall_left--;
      end
      en = e; en_prev = e;
      if (noise_mode == 1) wr_start = ($urandom_range(3) == 0);
      else if (noise_mode == 2) wr_start = (n == noise_a || n == total - 1);
    end
    check("burst_timeout", 32'(reached), 32'(1));
    @(posedge clk); #1;
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    done_exp++;
    check("done_count", 32'(done_cnt), 32'(done_exp));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; wr_start = 1'b0; bl = 6'd16; pat = '0; pre = 3'd2;
    post = 2'b01; crc_en = 1'b0;
    fill_random();
    repeat (3) @(posedge clk);
    #1 check("reset_out", 32'({dqs, dqs_oe, dq, dq_oe, busy, done, data_req}), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    fill_random();
    run_burst(3'd2, 8'b0000_0010, 6'd16, 2'b01, 1'b0, 0, 0, 0, 0, 0);
    fill_random();
    run_burst(3'd4, 8'b0000_1010, 6'd8, 2'b10, 1'b0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) data_arr[i] = 8'h00;
    data_arr[7] = 8'h01;
    run_burst(3'd2, 8'b0000_0010, 6'd8, 2'b01, 1'b1, 0, 0, 0, 0, 0);
    fill_random();
    run_burst(3'd3, 8'h5A, 6'd16, 2'b01, 1'b0, 0, 2, 9, 0, 0);
    fill_random();
    run_burst(3'd2, 8'h02, 6'd16, 2'b10, 1'b1, 0, 0, 0, 10, 0);
    fill_random();
    run_burst(3'd2, 8'h02, 6'd16, 2'b01, 1'b0, 0, 0, 0, 0, 2);
    repeat (2) @(posedge clk);
    fill_random();
    run_burst(3'd2, 8'h02, 6'd16, 2'b01, 1'b0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [5:0] rbl;
      case ($urandom_range(3))
        0: rbl = 6'd8;
        1: rbl = 6'd16;
        2: rbl = 6'd32;
        default: rbl = 6'($urandom);
      endcase
      fill_random();
      run_burst(3'($urandom), 8'($urandom), rbl, 2'($urandom), 1'($urandom),
                int'($urandom_range(2)) * 15, int'($urandom_range(1)), 0, 0, 0);
      repeat ($urandom_range(2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
